// File: rtl/rvl_reg_arbiter.sv
// rtl/rvl_reg_arbiter.sv - round-robin arbiter sharing one Reveal user register port
module rvl_reg_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int RD_LATENCY = 1
) (
  input  logic                             sys_clk,
  input  logic                             rstn,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ-1:0]               req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic [NUM_REQ-1:0]               rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  output logic                             busy,
  output logic                             usr_ce,
  output logic                             usr_we,
  output logic [ADDR_WIDTH-1:0]            usr_addr,
  output logic [DATA_WIDTH-1:0]            usr_wdata,
  input  logic [DATA_WIDTH-1:0]            usr_rdata
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);
  localparam logic [3:0]       CNT_LOAD = 4'(RD_LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RD_WAIT, S_RESP} state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      last_q, last_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rdata_d;

  logic                  grant_found;
  logic [IDX_W-1:0]      grant_idx;
  logic [IDX_W-1:0]      cand;
  logic [NUM_REQ-1:0]    last_onehot;

  // Round-robin search: first valid requester after the last one served
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(last_q) + k) % NUM_REQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Next-state logic, request latching and the combinational accept pulse
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    rdata_d   = rsp_rdata;
    req_ready = '0;
    case (state_q)
      S_IDLE: begin
        if (grant_found && rstn) begin
          req_ready[grant_idx] = 1'b1;
          we_d    = req_we[grant_idx];
          addr_d  = req_addr[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
          wdata_d = req_wdata[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
          last_d  = grant_idx;
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (we_q) begin
          rdata_d = '0;
          state_d = S_RESP;
        end else begin
          cnt_d   = CNT_LOAD;
          state_d = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        if (cnt_q == 4'd0) begin
          rdata_d = usr_rdata;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    last_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << last_d;
  end

  // State, pointer and registered register-port / response outputs
  always_ff @(posedge sys_clk) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      last_q    <= LAST_RST;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      busy      <= 1'b0;
      usr_ce    <= 1'b0;
      usr_we    <= 1'b0;
      usr_addr  <= '0;
      usr_wdata <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      busy      <= (state_d != S_IDLE);
      usr_ce    <= (state_d == S_ACCESS);
      usr_we    <= (state_d == S_ACCESS) && we_d;
      usr_addr  <= (state_d == S_ACCESS) ? addr_d : '0;
      usr_wdata <= (state_d == S_ACCESS) ? wdata_d : '0;
      rsp_valid <= (state_d == S_RESP) ? last_onehot : '0;
      rsp_rdata <= rdata_d;
    end
  end

endmodule

// File: tb/tb_rvl_reg_arbiter.sv
// tb/tb_rvl_reg_arbiter.sv - self-checking bench for rvl_reg_arbiter
module tb_rvl_reg_arbiter;

  localparam int NR  = 4;
  localparam int AW  = 16;
  localparam int DW  = 16;
  localparam int RDL = 3;

  typedef struct {
    int          idx;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
  } txn_t;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic [NR-1:0]     req_valid = '0;
  logic [NR-1:0]     req_we = '0;
  logic [NR*AW-1:0]  req_addr = '0;
  logic [NR*DW-1:0]  req_wdata = '0;
  logic [NR-1:0]     req_ready;
  logic [NR-1:0]     rsp_valid;
  logic [DW-1:0]     rsp_rdata;
  logic              busy;
  logic              usr_ce;
  logic              usr_we;
  logic [AW-1:0]     usr_addr;
  logic [DW-1:0]     usr_wdata;
  logic [DW-1:0]     usr_rdata;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   t_acc = -100;
  int   t_rsp = -100;
  logic prev_ce = 1'b0;
  txn_t sb[$];
  txn_t vec[8];

  logic [15:0] mem [256];
  logic        mem_init = 1'b0;
  int          rd_cnt = 0;
  logic [15:0] rd_val = '0;

  rvl_reg_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(RDL)) dut (
    .sys_clk(clk), .rstn(rstn), .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
    .usr_ce(usr_ce), .usr_we(usr_we), .usr_addr(usr_addr),
    .usr_wdata(usr_wdata), .usr_rdata(usr_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Register-file model: read data is valid only in the cycle RDL after the strobe
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'h1000 + 16'(i);
      mem_init <= 1'b1;
    end else if (usr_ce && usr_we) begin
      mem[usr_addr[7:0]] <= usr_wdata;
    end
    if (usr_ce && !usr_we) begin
      rd_cnt <= RDL;
      rd_val <= mem[usr_addr[7:0]];
    end else if (rd_cnt != 0) begin
      rd_cnt <= rd_cnt - 1;
    end
  end
  assign usr_rdata = (rd_cnt == 1) ? rd_val : 16'hDEAD;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: strobe contents, response routing, latencies, handshake rules
  always @(negedge clk) begin
    txn_t e;
    if (rstn) begin
      if (req_ready != '0) begin
        chk("ready_onehot", 32'($onehot(req_ready)), 32'd1);
        chk("ready_has_valid", 32'((req_ready & ~req_valid) == '0), 32'd1);
        chk("ready_not_busy", 32'(busy), 32'd0);
        t_acc = cyc;
      end
      if (usr_ce) begin
        chk("ce_consecutive", 32'(prev_ce), 32'd0);
        chk("ce_latency", cyc, t_acc + 1);
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL ce_unexpected actual=usr_ce addr %0h expected=no strobe", usr_addr);
        end else begin
          chk("ce_we", 32'(usr_we), 32'(sb[0].we));
          chk("ce_addr", 32'(usr_addr), 32'(sb[0].addr));
          chk("ce_wdata", 32'(usr_wdata), 32'(sb[0].wdata));
        end
      end
      if (rsp_valid != '0) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL rsp_unexpected actual=%b expected=none", rsp_valid);
        end else begin
          e = sb.pop_front();
          chk("rsp_valid", 32'(rsp_valid), 32'(1) << e.idx);
          chk("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
          chk("rsp_latency", cyc, t_acc + 2 + (e.we ? 0 : RDL));
          t_rsp = cyc;
        end
      end
    end
    prev_ce = usr_ce;
  end

  task automatic set_req(input int idx, input logic we, input logic [15:0] addr, input logic [15:0] wdata);
    req_we[idx]              = we;
    req_addr[idx*AW +: AW]   = addr;
    req_wdata[idx*DW +: DW]  = wdata;
  endtask

  task automatic push(input int idx, input logic we, input logic [15:0] addr, input logic [15:0] wdata, input logic [15:0] rdata);
    txn_t e;
    e = '{idx, we, addr, wdata, rdata};
    sb.push_back(e);
  endtask

  task automatic wait_ready(input int idx, input int bound, output int t);
    int n;
    n = 0;
    t = -1;
    while (n < bound) begin
      @(negedge clk);
      n++;
      if (req_ready != '0) break;
    end
    if (req_ready == '0) begin
      checks++; errors++;
      $display("FAIL grant_timeout actual=no req_ready expected=req_ready[%0d]", idx);
    end else begin
      chk("grant_idx", 32'(req_ready), 32'(1) << idx);
      t = cyc;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain actual=%0d pending expected=0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_usr_ce"}, 32'(usr_ce), 32'd0);
    chk({tag, "_usr_addr"}, 32'(usr_addr), 32'd0);
    chk({tag, "_usr_wdata"}, 32'(usr_wdata), 32'd0);
  endtask

  initial begin
    int t, tp, t1, t2;
    int order[6];
    order = '{0, 1, 2, 3, 0, 1};

    vec[0] = '{0, 1'b1, 16'h0003, 16'hBEEF, 16'h0000};
    vec[1] = '{1, 1'b0, 16'h0003, 16'h0000, 16'hBEEF};
    vec[2] = '{3, 1'b1, 16'h000A, 16'h1234, 16'h0000};
    vec[3] = '{2, 1'b0, 16'h000A, 16'h0000, 16'h1234};
    vec[4] = '{0, 1'b0, 16'h0012, 16'h0000, 16'hA002};
    vec[5] = '{3, 1'b0, 16'h0055, 16'h0000, 16'h1055};
    vec[6] = '{1, 1'b1, 16'hFF00, 16'h5A5A, 16'h0000};
    vec[7] = '{2, 1'b0, 16'hFF00, 16'h0000, 16'h5A5A};

    // All four requesters write, valid held from reset
    for (int i = 0; i < NR; i++) set_req(i, 1'b1, 16'h0010 + 16'(i), 16'hA000 + 16'(i));
    req_valid = 4'b1111;
    for (int k = 0; k < 6; k++) push(order[k], 1'b1, 16'h0010 + 16'(order[k]), 16'hA000 + 16'(order[k]), 16'h0000);
    repeat (3) begin
      @(negedge clk);
      chk_idle_outputs("reset");
    end
    @(posedge clk); #1 rstn = 1'b1;
    tp = 0;
    for (int k = 0; k < 6; k++) begin
      wait_ready(order[k], 20, t);
      if (k > 0) chk("grant_interval", t - tp, 32'd3);
      tp = t;
    end
    @(posedge clk); #1 req_valid = '0;
    drain();

    // Table-driven single transactions
    for (int v = 0; v < 8; v++) begin
      @(posedge clk); #1;
      set_req(vec[v].idx, vec[v].we, vec[v].addr, vec[v].wdata);
      push(vec[v].idx, vec[v].we, vec[v].addr, vec[v].wdata, vec[v].rdata);
      req_valid = 4'(1) << vec[v].idx;
      wait_ready(vec[v].idx, 20, t);
      @(posedge clk); #1 req_valid = '0;
      drain();
    end

    // Round robin between req1 and req3 with both held
    @(posedge clk); #1;
    set_req(1, 1'b1, 16'h0021, 16'hC001);
    push(1, 1'b1, 16'h0021, 16'hC001, 16'h0000);
    req_valid = 4'b0010;
    wait_ready(1, 20, t);
    @(posedge clk); #1;
    set_req(3, 1'b1, 16'h0023, 16'hC003);
    push(3, 1'b1, 16'h0023, 16'hC003, 16'h0000);
    push(1, 1'b1, 16'h0021, 16'hC001, 16'h0000);
    req_valid = 4'b1010;
    wait_ready(3, 20, t);
    wait_ready(1, 20, t);
    @(posedge clk); #1 req_valid = '0;
    drain();

    // req1 withdraws while req0 is in flight: no strobe may follow for it
    @(posedge clk); #1;
    set_req(0, 1'b1, 16'h0024, 16'hC004);
    push(0, 1'b1, 16'h0024, 16'hC004, 16'h0000);
    req_valid = 4'b0001;
    wait_ready(0, 20, t);
    @(posedge clk); #1;
    set_req(1, 1'b1, 16'h0025, 16'hC005);
    req_valid = 4'b0010;
    @(posedge clk); #1 req_valid = '0;
    drain();
    repeat (5) begin
      @(negedge clk);
      chk("withdraw_no_ready", 32'(req_ready), 32'd0);
      chk("withdraw_no_ce", 32'(usr_ce), 32'd0);
    end

    // Reset during RD_WAIT aborts the read; pointer returns so req0 wins next
    @(posedge clk); #1;
    set_req(3, 1'b0, 16'h000A, 16'h0000);
    push(3, 1'b0, 16'h000A, 16'h0000, 16'h1234);
    req_valid = 4'b1000;
    wait_ready(3, 20, t);
    @(posedge clk); #1 req_valid = '0;
    @(negedge clk);
    chk("abort_ce_seen", 32'(usr_ce), 32'd1);
    @(posedge clk); #1 rstn = 1'b0;
    @(negedge clk);
    chk("abort_busy_before_edge", 32'(busy), 32'd1);
    chk("abort_no_rsp_pre", 32'(rsp_valid), 32'd0);
    sb.delete();
    for (int i = 0; i < NR; i++) set_req(i, 1'b1, 16'h0040 + 16'(i), 16'hD000 + 16'(i));
    req_valid = 4'b1111;
    repeat (2) begin
      @(negedge clk);
      chk_idle_outputs("abort");
    end
    push(0, 1'b1, 16'h0040, 16'hD000, 16'h0000);
    @(posedge clk); #1 rstn = 1'b1;
    wait_ready(0, 1, t);
    @(posedge clk); #1 req_valid = '0;
    drain();

    // Back-to-back read then write from req0
    @(posedge clk); #1;
    set_req(0, 1'b0, 16'h0003, 16'h0000);
    push(0, 1'b0, 16'h0003, 16'h0000, 16'hBEEF);
    req_valid = 4'b0001;
    wait_ready(0, 20, t1);
    @(posedge clk); #1;
    set_req(0, 1'b1, 16'h0030, 16'h7777);
    push(0, 1'b1, 16'h0030, 16'h7777, 16'h0000);
    wait_ready(0, 30, t2);
    chk("b2b_after_rsp", 32'(t2 > t_rsp), 32'd1);
    chk("b2b_read_period", t2 - t1, 32'(3 + RDL));
    @(posedge clk); #1 req_valid = '0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0d cycles expected=finish", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rvl_reg_arbiter.md
Name: rvl_reg_arbiter

Overview:
Shares the single Reveal controller user register port (ce/we/addr/wdata/rdata) between NUM_REQ independent requesters. Uses round-robin arbitration with a valid/ready request handshake and a per-requester response pulse. Sits between user logic (e.g. counter-driven writers, seven-segment reader) and rvl_ctrl_mod. Sequences each access as a single-cycle usr_ce strobe plus a fixed read-data wait.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_WIDTH, 16, register address width
DATA_WIDTH, 16, register data width
RD_LATENCY, 1, cycles from usr_ce strobe to valid usr_rdata (1..15)

Ports:
sys_clk  in  1  single clock; all logic on rising edge
rstn  in  1  synchronous active-low reset
req_valid  in  NUM_REQ  per-requester request valid
req_we  in  NUM_REQ  per-requester write(1)/read(0)
req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data, same packing
req_ready  out  NUM_REQ  one-hot accept pulse
rsp_valid  out  NUM_REQ  one-hot completion pulse
rsp_rdata  out  DATA_WIDTH  read data, shared, qualified by rsp_valid
busy  out  1  transaction in flight (state != IDLE)
usr_ce  out  1  register-port chip enable
usr_we  out  1  register-port write enable
usr_addr  out  ADDR_WIDTH  register-port address
usr_wdata  out  DATA_WIDTH  register-port write data
usr_rdata  in  DATA_WIDTH  register-port read data

Behaviour:
- Reset is synchronous and active-low, sampled on sys_clk rising edge. While rstn=0: state=IDLE, RR pointer last=NUM_REQ-1, all registered outputs 0. req_ready is forced 0.
- FSM states: IDLE, ACCESS, RD_WAIT, RESP.
- IDLE: if any req_valid, pick winner w = first set bit searching last+1, last+2, ... (mod NUM_REQ). Same cycle: req_ready[w]=1 (combinational from state and req_valid), latch we/addr/wdata of w, last<=w, go ACCESS. req_ready is never asserted outside IDLE and never without a matching req_valid.
- ACCESS (exactly 1 cycle): usr_ce=1, usr_we=latched we, usr_addr/usr_wdata=latched values. Write -> RESP. Read -> RD_WAIT with counter=RD_LATENCY-1.
- RD_WAIT: decrement counter each cycle. At count 0, capture usr_rdata into rsp_rdata, go RESP.
- RESP (1 cycle): rsp_valid[w]=1, go IDLE. For writes, rsp_rdata=0.
- usr_ce/usr_we/usr_addr/usr_wdata are registered and held 0 in every state except ACCESS.
- Latency, with accept at cycle T: usr_ce at T+1; write rsp_valid at T+2; read data sampled at T+1+RD_LATENCY; read rsp_valid at T+2+RD_LATENCY.
- Throughput: one accept per 3 cycles for writes and per 3+RD_LATENCY cycles for reads. No pipelining; one outstanding transaction.
- Requesters hold req_we/addr/wdata stable while req_valid=1 until req_ready. Dropping req_valid before ready withdraws the request with no side effect.
- Fairness: a requester that is re-served with req_valid held continuously waits behind all other active requesters. Worst-case wait is NUM_REQ-1 transactions.
- Simultaneous requests: resolved by RR order only; there is no fixed priority after reset (first grant after reset goes to requester 0).
- Reset mid-transaction: aborts immediately. No rsp_valid is issued, usr_ce drops at the next edge, and the pointer returns to NUM_REQ-1.
- busy is registered: 1 in ACCESS, RD_WAIT and RESP.

Test Plan:
- Single write: req0 we=1 addr=0x0003 wdata=0xBEEF -> req_ready[0] at T; usr_ce=1, usr_we=1, addr=0x0003, wdata=0xBEEF at T+1 only; rsp_valid=0001 at T+2.
- Single read, RD_LATENCY=3: req2 addr=0x000A, model returns 0x1234 -> usr_ce at T+1 with usr_we=0; rsp_valid=0100 at T+5; rsp_rdata=0x1234.
- All four req_valid held high from reset, writes -> grants in order 0,1,2,3,0,1, one every 3 cycles; no grant while busy=1.
- req1 and req3 held high after a grant to 1 -> next grant goes to 3, then 1; req1 dropped before ready -> no usr_ce is produced for it.
- rstn=0 asserted in RD_WAIT -> no rsp_valid; all outputs 0 the following cycle; the first grant after release goes to requester 0.
- Back-to-back read then write from req0 -> the second req_ready comes no earlier than one cycle after the first rsp_valid; usr_ce never high on consecutive cycles.
